// File: rtl/vga_text_renderer.sv
// 80x25 text-mode pixel stage: counters in, RGB 4:4:4 plus delayed syncs out, five clocks later.
// Character words come from a synchronous text RAM; glyph rows come from a synchronous font ROM.
module vga_text_renderer #(
  parameter logic HSYNC_IDLE   = 1'b1,
  parameter logic VSYNC_IDLE   = 1'b0,
  parameter int   BLINK_FRAMES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  input  logic [9:0]  pixelCnt,
  input  logic [8:0]  lineCnt,
  input  logic        compBlank,
  output logic [10:0] charAddr,
  input  logic [15:0] charData,
  output logic [11:0] fontAddr,
  input  logic [7:0]  fontData,
  input  logic [6:0]  cursorCol,
  input  logic [4:0]  cursorRow,
  input  logic        cursorEn,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hSyncOut,
  output logic        vSyncOut
);

  function automatic logic [3:0] irgb_level(input logic c, input logic i);
    case ({c, i})
      2'b00:   irgb_level = 4'h0;
      2'b01:   irgb_level = 4'h5;
      2'b10:   irgb_level = 4'hA;
      2'b11:   irgb_level = 4'hF;
      default: irgb_level = 4'h0;
    endcase
  endfunction

  logic        w_active;
  logic [6:0]  w_col;
  logic [4:0]  w_row;
  logic [10:0] w_char_addr;
  logic        w_cursor;
  logic        w_vs_edge;
  logic        w_pix;
  logic [3:0]  w_irgb;

  logic [3:0]  r_act;
  logic [3:0]  r_cursor;
  logic [2:0]  r_bit1, r_bit2, r_bit3, r_bit4;
  logic [3:0]  r_row1, r_row2;
  logic [3:0]  r_fg3, r_bg3, r_fg4, r_bg4;
  logic [3:0]  r_hs_pipe;
  logic [3:0]  r_vs_pipe;
  logic        r_vs_prev;
  logic [7:0]  r_frame_cnt;
  logic        r_blink;

  // Cell decode; the cursor flag already folds in enable and the two underline glyph rows.
  always_comb begin
    w_col       = pixelCnt[9:3];
    w_row       = lineCnt[8:4];
    w_active    = (pixelCnt < 10'd640) && (lineCnt < 9'd400) && !compBlank;
    w_char_addr = ({6'd0, w_row} << 6) + ({6'd0, w_row} << 4) + {4'd0, w_col};
    w_cursor    = w_active && cursorEn && (w_row == cursorRow) && (w_col == cursorCol)
                  && (lineCnt[3:1] == 3'b111);
    w_vs_edge   = (vSyncIn != VSYNC_IDLE) && (r_vs_prev == VSYNC_IDLE);
  end

  // Final pixel select: font bit, forced on by the cursor underline during the lit blink phase.
  always_comb begin
    if (r_cursor[3] && r_blink) begin
      w_pix = 1'b1;
    end else begin
      w_pix = fontData[3'd7 - r_bit4];
    end
    w_irgb = w_pix ? r_fg4 : r_bg4;
  end

  // Five-stage render pipeline; compBlank travels inside the active bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      charAddr  <= 11'd0;
      fontAddr  <= 12'd0;
      red       <= 4'd0;
      green     <= 4'd0;
      blue      <= 4'd0;
      hSyncOut  <= HSYNC_IDLE;
      vSyncOut  <= VSYNC_IDLE;
      r_hs_pipe <= {4{HSYNC_IDLE}};
      r_vs_pipe <= {4{VSYNC_IDLE}};
      r_act     <= 4'd0;
      r_cursor  <= 4'd0;
      r_bit1    <= 3'd0;
      r_bit2    <= 3'd0;
      r_bit3    <= 3'd0;
      r_bit4    <= 3'd0;
      r_row1    <= 4'd0;
      r_row2    <= 4'd0;
      r_fg3     <= 4'd0;
      r_bg3     <= 4'd0;
      r_fg4     <= 4'd0;
      r_bg4     <= 4'd0;
    end else begin
      charAddr  <= w_active ? w_char_addr : 11'd0;
      r_act     <= {r_act[2:0], w_active};
      r_cursor  <= {r_cursor[2:0], w_cursor};
      r_bit1    <= pixelCnt[2:0];
      r_bit2    <= r_bit1;
      r_bit3    <= r_bit2;
      r_bit4    <= r_bit3;
      r_row1    <= lineCnt[3:0];
      r_row2    <= r_row1;
      fontAddr  <= {charData[7:0], r_row2};
      r_fg3     <= charData[11:8];
      r_bg3     <= charData[15:12];
      r_fg4     <= r_fg3;
      r_bg4     <= r_bg3;
      r_hs_pipe <= {r_hs_pipe[2:0], hSyncIn};
      r_vs_pipe <= {r_vs_pipe[2:0], vSyncIn};
      hSyncOut  <= r_hs_pipe[3];
      vSyncOut  <= r_vs_pipe[3];
      if (r_act[3]) begin
        red   <= irgb_level(w_irgb[2], w_irgb[3]);
        green <= irgb_level(w_irgb[1], w_irgb[3]);
        blue  <= irgb_level(w_irgb[0], w_irgb[3]);
      end else begin
        red   <= 4'd0;
        green <= 4'd0;
        blue  <= 4'd0;
      end
    end
  end

  // Frame counter and cursor blink phase, stepped on each vertical sync assertion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vs_prev   <= VSYNC_IDLE;
      r_frame_cnt <= 8'd0;
      r_blink     <= 1'b0;
    end else begin
      r_vs_prev <= vSyncIn;
      if (w_vs_edge) begin
        if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= 8'd0;
          r_blink     <= ~r_blink;
        end else begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer with behavioural text RAM and font ROM.
// Expected colours are hand-derived from the IRGB table; syncs are checked against their own history.
module tb_vga_text_renderer;

  logic        clock = 1'b0;
  logic        reset;
  logic        hSyncIn, vSyncIn, compBlank;
  logic [9:0]  pixelCnt;
  logic [8:0]  lineCnt;
  logic [10:0] charAddr;
  logic [15:0] charData;
  logic [11:0] fontAddr;
  logic [7:0]  fontData;
  logic [6:0]  cursorCol;
  logic [4:0]  cursorRow;
  logic        cursorEn;
  logic [3:0]  red, green, blue;
  logic        hSyncOut, vSyncOut;

  logic [15:0] tram  [0:2047];
  logic [7:0]  from  [0:4095];
  logic [11:0] rgb_h [0:255];
  logic        hs_h  [0:255];
  logic        vs_h  [0:255];
  int          n_step;
  int          checks;
  int          failures;

  vga_text_renderer #(.BLINK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
    .pixelCnt(pixelCnt), .lineCnt(lineCnt), .compBlank(compBlank),
    .charAddr(charAddr), .charData(charData), .fontAddr(fontAddr), .fontData(fontData),
    .cursorCol(cursorCol), .cursorRow(cursorRow), .cursorEn(cursorEn),
    .red(red), .green(green), .blue(blue), .hSyncOut(hSyncOut), .vSyncOut(vSyncOut)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    charData <= tram[charAddr];
    fontData <= from[fontAddr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One counter sample per clock; outputs of the sample four steps back are checked afterwards.
  task automatic step(input int px, input int ln, input logic hs, input logic vs, input logic bl,
                      input logic [10:0] ea, input logic [11:0] erg);
    pixelCnt  = 10'(px);
    lineCnt   = 9'(ln);
    hSyncIn   = hs;
    vSyncIn   = vs;
    compBlank = bl;
    rgb_h[n_step] = erg;
    hs_h[n_step]  = hs;
    vs_h[n_step]  = vs;
    @(posedge clock); #1;
    chk("charAddr", {5'd0, charAddr}, {5'd0, ea});
    if (n_step >= 4) begin
      chk("rgb", {4'd0, red, green, blue}, {4'd0, rgb_h[n_step-4]});
      chk("hSyncOut", {15'd0, hSyncOut}, {15'd0, hs_h[n_step-4]});
      chk("vSyncOut", {15'd0, vSyncOut}, {15'd0, vs_h[n_step-4]});
    end
    n_step++;
  endtask

  task automatic frame_pulse();
    for (int i = 0; i < 4; i++) step(700, 420, 1'b1, 1'b0, 1'b1, 11'd0, 12'h000);
    step(700, 420, 1'b0, 1'b1, 1'b1, 11'd0, 12'h000);
    step(700, 420, 1'b1, 1'b0, 1'b1, 11'd0, 12'h000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_step   = 0;
    for (int i = 0; i < 2048; i++) tram[i] = 16'h0000;
    for (int i = 0; i < 4096; i++) from[i] = 8'h00;
    tram[0]   = 16'h4A00;
    tram[162] = 16'h1F41;
    tram[165] = 16'h1F41;
    tram[244] = 16'h1F41;
    tram[245] = 16'h1F41;
    from[12'h000] = 8'h80;
    from[12'h003] = 8'hFF;
    from[12'h413] = 8'h80;
    cursorCol = 7'd5;
    cursorRow = 5'd3;
    cursorEn  = 1'b1;

    reset     = 1'b1;
    pixelCnt  = 10'd100;
    lineCnt   = 9'd50;
    hSyncIn   = 1'b0;
    vSyncIn   = 1'b1;
    compBlank = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("rst_rgb", {4'd0, red, green, blue}, 16'h0000);
    chk("rst_hsync", {15'd0, hSyncOut}, 16'h0001);
    chk("rst_vsync", {15'd0, vSyncOut}, 16'h0000);
    chk("rst_charAddr", {5'd0, charAddr}, 16'h0000);
    chk("rst_fontAddr", {4'd0, fontAddr}, 16'h0000);
    vSyncIn = 1'b0;
    reset   = 1'b0;

    // Cell (2,2), glyph row 3: addressing and latency
    step(16, 35, 1'b1, 1'b0, 1'b0, 11'd162, 12'hFFF);
    step(17, 35, 1'b1, 1'b0, 1'b0, 11'd162, 12'h00A);
    chk("fontAddr_early", {4'd0, fontAddr}, 16'h0000);
    step(18, 35, 1'b1, 1'b0, 1'b0, 11'd162, 12'h00A);
    chk("fontAddr", {4'd0, fontAddr}, 16'h0413);
    step(19, 35, 1'b1, 1'b0, 1'b0, 11'd162, 12'h00A);
    chk("rgb_before_latency", {4'd0, red, green, blue}, 16'h0000);
    for (int p = 20; p < 24; p++) step(p, 35, 1'b1, 1'b0, 1'b0, 11'd162, 12'h00A);
    step(24, 35, 1'b0, 1'b0, 1'b0, 11'd163, 12'h000);
    step(25, 35, 1'b0, 1'b1, 1'b0, 11'd163, 12'h000);
    step(26, 35, 1'b1, 1'b0, 1'b0, 11'd163, 12'h000);

    // Blanked regions and compBlank
    step(640, 35, 1'b1, 1'b0, 1'b0, 11'd0, 12'h000);
    step(799, 35, 1'b1, 1'b0, 1'b0, 11'd0, 12'h000);
    step(100, 400, 1'b1, 1'b0, 1'b0, 11'd0, 12'h000);
    step(100, 448, 1'b1, 1'b0, 1'b0, 11'd0, 12'h000);
    step(16, 35, 1'b1, 1'b0, 1'b1, 11'd0, 12'h000);

    // Frame wrap into cell (0,0)
    step(799, 448, 1'b1, 1'b0, 1'b1, 11'd0, 12'h000);
    step(0, 0, 1'b1, 1'b0, 1'b0, 11'd0, 12'h5F5);
    step(1, 0, 1'b1, 1'b0, 1'b0, 11'd0, 12'hA00);
    step(2, 0, 1'b1, 1'b0, 1'b0, 11'd0, 12'hA00);
    for (int i = 0; i < 4; i++) step(700, 420, 1'b1, 1'b0, 1'b1, 11'd0, 12'h000);

    // Asynchronous reset mid-line with non-idle syncs in flight
    for (int i = 0; i < 5; i++) step(16, 35, 1'b0, 1'b1, 1'b0, 11'd162, 12'hFFF);
    #2 reset = 1'b1;
    #1;
    chk("async_rgb", {4'd0, red, green, blue}, 16'h0000);
    chk("async_hsync", {15'd0, hSyncOut}, 16'h0001);
    chk("async_vsync", {15'd0, vSyncOut}, 16'h0000);
    chk("async_charAddr", {5'd0, charAddr}, 16'h0000);
    chk("async_fontAddr", {4'd0, fontAddr}, 16'h0000);
    repeat (2) begin @(posedge clock); #1; end
    chk("held_rgb", {4'd0, red, green, blue}, 16'h0000);
    chk("held_charAddr", {5'd0, charAddr}, 16'h0000);
    pixelCnt  = 10'd700;
    lineCnt   = 9'd420;
    hSyncIn   = 1'b1;
    vSyncIn   = 1'b0;
    compBlank = 1'b1;
    reset     = 1'b0;
    n_step    = 0;

    // Cursor blink with BLINK_FRAMES=2: lit in frames 2 and 3
    step(40, 62, 1'b1, 1'b0, 1'b0, 11'd245, 12'h00A);
    step(47, 63, 1'b1, 1'b0, 1'b0, 11'd245, 12'h00A);
    frame_pulse();
    step(40, 62, 1'b1, 1'b0, 1'b0, 11'd245, 12'h00A);
    frame_pulse();
    step(40, 62, 1'b1, 1'b0, 1'b0, 11'd245, 12'hFFF);
    step(47, 63, 1'b1, 1'b0, 1'b0, 11'd245, 12'hFFF);
    step(40, 61, 1'b1, 1'b0, 1'b0, 11'd245, 12'h00A);
    step(39, 62, 1'b1, 1'b0, 1'b0, 11'd244, 12'h00A);
    step(40, 46, 1'b1, 1'b0, 1'b0, 11'd165, 12'h00A);
    cursorEn = 1'b0;
    step(40, 62, 1'b1, 1'b0, 1'b0, 11'd245, 12'h00A);
    cursorEn = 1'b1;
    frame_pulse();
    step(40, 62, 1'b1, 1'b0, 1'b0, 11'd245, 12'hFFF);
    frame_pulse();
    step(40, 62, 1'b1, 1'b0, 1'b0, 11'd245, 12'h00A);
    frame_pulse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
